// File: rtl/mem_access_wb_reg_if.sv
// MEM-stage request, data-SRAM and MEM/WB register signals shared by the
// pipeline side (master) and the access/WB block (slave).
interface mem_access_wb_reg_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  mem_valid;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [2:0]            load_store_mem;
    logic [ADDR_W-1:0]     addr_mem;
    logic [DATA_W-1:0]     wdata_mem;
    logic                  exc_flush;
    logic                  wb_allowin;
    logic                  mem_allowin;
    logic                  data_sram_en;
    logic [DATA_W/8-1:0]   data_sram_wen;
    logic [ADDR_W-1:0]     data_sram_addr;
    logic [DATA_W-1:0]     data_sram_wdata;
    logic [DATA_W-1:0]     data_sram_rdata;
    logic                  wb_valid;
    logic [2:0]            load_store_wb;
    logic [1:0]            data_sram_addr_byte_wb;
    logic [DATA_W-1:0]     DMout_wb;
    logic                  adel_wb;
    logic                  ades_wb;
    logic [ADDR_W-1:0]     badvaddr_wb;

    modport master (
        output mem_valid, mem_rd, mem_wr, load_store_mem, addr_mem, wdata_mem,
               exc_flush, wb_allowin, data_sram_rdata,
        input  mem_allowin, data_sram_en, data_sram_wen, data_sram_addr,
               data_sram_wdata, wb_valid, load_store_wb, data_sram_addr_byte_wb,
               DMout_wb, adel_wb, ades_wb, badvaddr_wb
    );

    modport slave (
        input  mem_valid, mem_rd, mem_wr, load_store_mem, addr_mem, wdata_mem,
               exc_flush, wb_allowin, data_sram_rdata,
        output mem_allowin, data_sram_en, data_sram_wen, data_sram_addr,
               data_sram_wdata, wb_valid, load_store_wb, data_sram_addr_byte_wb,
               DMout_wb, adel_wb, ades_wb, badvaddr_wb
    );
endinterface

// File: rtl/mem_access_wb_reg.sv
// MEM-stage data SRAM access with alignment checks, plus the MEM/WB register
// that keeps the one-cycle SRAM read word alive while WB is stalled.
module mem_access_wb_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    mem_access_wb_reg_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FRESH = 2'd1,
        ST_HELD  = 2'd2
    } rd_state_e;

    rd_state_e          state_r;
    rd_state_e          state_s;
    logic               go_s;
    logic               misalign_s;
    logic               access_s;
    logic               hold_load_s;
    logic               mem_allowin_s;
    logic [3:0]         wen_s;
    logic [DATA_W-1:0]  wdata_s;
    logic [2:0]         ls_r;
    logic [1:0]         byte_r;
    logic               adel_r;
    logic               ades_r;
    logic [ADDR_W-1:0]  badv_r;
    logic [DATA_W-1:0]  hold_r;

    // Halfwords need bit 0 clear, words need both low bits clear; bytes never fault.
    function automatic logic misaligned(input logic [2:0] ls, input logic [1:0] lo);
        logic m;
        case (ls)
            3'b010, 3'b011: m = lo[0];
            3'b100:         m = (lo != 2'b00);
            default:        m = 1'b0;
        endcase
        return m;
    endfunction

    // Handshake, alignment and SRAM request decode.
    always_comb begin
        mem_allowin_s = (state_r == ST_EMPTY) | bus.wb_allowin;
        go_s          = bus.mem_valid & mem_allowin_s & ~bus.exc_flush;
        misalign_s    = misaligned(bus.load_store_mem, bus.addr_mem[1:0]);
        access_s      = go_s & (bus.mem_rd | bus.mem_wr) & ~misalign_s;
        wen_s         = 4'b0000;
        wdata_s       = bus.wdata_mem;
        case (bus.load_store_mem)
            3'b000, 3'b001: begin
                wdata_s = {4{bus.wdata_mem[7:0]}};
                wen_s   = 4'b0001 << bus.addr_mem[1:0];
            end
            3'b010, 3'b011: begin
                wdata_s = {2{bus.wdata_mem[15:0]}};
                wen_s   = bus.addr_mem[1] ? 4'b1100 : 4'b0011;
            end
            3'b100: begin
                wdata_s = bus.wdata_mem;
                wen_s   = 4'b1111;
            end
            default: begin
                wdata_s = bus.wdata_mem;
                wen_s   = 4'b0000;
            end
        endcase
        if (!(access_s && bus.mem_wr)) begin
            wen_s = 4'b0000;
        end else begin
            wen_s = wen_s;
        end
    end

    // Read-data FSM next state: a clean load starts FRESH, anything else valid is HELD.
    always_comb begin
        state_s     = state_r;
        hold_load_s = 1'b0;
        if (go_s) begin
            if (bus.mem_rd && !misalign_s) begin
                state_s = ST_FRESH;
            end else begin
                state_s = ST_HELD;
            end
        end else begin
            case (state_r)
                ST_FRESH: begin
                    if (bus.wb_allowin || bus.exc_flush) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s     = ST_HELD;
                        hold_load_s = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (bus.wb_allowin || bus.exc_flush) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_HELD;
                    end
                end
                ST_EMPTY: state_s = ST_EMPTY;
                default:  state_s = ST_EMPTY;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // MEM/WB payload register, loaded only when an instruction moves into WB.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ls_r   <= 3'b100;
            byte_r <= 2'b00;
            adel_r <= 1'b0;
            ades_r <= 1'b0;
            badv_r <= '0;
        end else if (go_s) begin
            ls_r   <= bus.load_store_mem;
            byte_r <= bus.addr_mem[1:0];
            adel_r <= bus.mem_rd & misalign_s;
            ades_r <= bus.mem_wr & misalign_s;
            badv_r <= bus.addr_mem;
        end
    end

    // Capture the SRAM word on the last cycle it is driven, i.e. when WB stalls in FRESH.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_r <= '0;
        end else if (hold_load_s) begin
            hold_r <= bus.data_sram_rdata;
        end
    end

    assign bus.mem_allowin            = mem_allowin_s;
    assign bus.data_sram_en           = access_s;
    assign bus.data_sram_wen          = wen_s;
    assign bus.data_sram_addr         = {bus.addr_mem[ADDR_W-1:2], 2'b00};
    assign bus.data_sram_wdata        = wdata_s;
    assign bus.wb_valid               = (state_r != ST_EMPTY);
    assign bus.load_store_wb          = ls_r;
    assign bus.data_sram_addr_byte_wb = byte_r;
    assign bus.DMout_wb               = (state_r == ST_FRESH) ? bus.data_sram_rdata : hold_r;
    assign bus.adel_wb                = adel_r;
    assign bus.ades_wb                = ades_r;
    assign bus.badvaddr_wb            = badv_r;
endmodule
